uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver.
- Deserialises frames of 1 start bit (0), WIDTH data bits LSB first, and 1 stop bit (1) from an idle-high line.
- Holds the received word in an output register with a valid/read handshake. Flags framing errors and overruns.
- Sits on the receive side of the buffered UART, opposite the transmitter, and feeds the RX buffer/consumer logic.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in bits/s.
- WIDTH, 8, data bits per frame (1..16).
- Derived: TICKS = CLOCK_FREQ / BAUD_RATE (integer division, must be >= 4); HALF = TICKS / 2 (integer division).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- rx_signal  input  1  serial line, idle high, asynchronous to clock.
- data  output  WIDTH  last correctly framed word.
- data_valid  output  1  high while data holds an unread word.
- data_read  input  1  consumer acknowledges data; sampled only while data_valid=1.
- frame_error  output  1  one-cycle pulse on bad stop bit.
- overrun  output  1  one-cycle pulse when an unread word is overwritten.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset (async, resetn=0):
  - Outputs: data=0, data_valid=0, frame_error=0, overrun=0, busy=0.
  - Internal: state=IDLE; synchroniser flops and their previous-value register preset to 1.
- Synchroniser: 2-flop on rx_signal; "line" below means the synchronised value (2-cycle latency). No majority voting.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. Sampling counter width $clog2(TICKS)+1.
- IDLE:
  - On the first cycle line=0 after previously being 1 -> START, with the sample point HALF cycles later.
  - A line already low when leaving reset or WAIT_HIGH does not start a frame.
- START, at the sample point:
  - line=0 -> DATA, bit_index=0, next sample TICKS cycles later.
  - line=1 -> glitch, back to IDLE; no outputs change.
- DATA:
  - Each sample point shifts line into shift register position bit_index (LSB first); next sample TICKS cycles later.
  - After bit WIDTH-1 -> STOP.
- STOP, at the sample point:
  - line=1 -> commit and go to IDLE in the same cycle. Next start edge is accepted immediately; no wait for the end of the stop bit, which supports back-to-back frames.
  - line=0 -> frame_error=1 for exactly one cycle, no commit, data and data_valid unchanged -> WAIT_HIGH.
- WAIT_HIGH: stays until line=1, then -> IDLE.
- Commit, on the cycle after the stop sample:
  - data <= shift register; data_valid <= 1.
  - If data_valid was 1 and data_read=0 on the commit cycle -> overrun=1 for one cycle. New word overwrites; data_valid stays 1.
  - If data_read=1 on the commit cycle -> no overrun; data_valid stays 1 with the new word.
- Read:
  - data_read=1 while data_valid=1 and no commit that cycle -> data_valid=0 next cycle; data retains its value.
  - data_read while data_valid=0 is ignored.
- busy = (state != IDLE), registered with state.
- frame_error and overrun never assert in the same cycle. Neither output is sticky.
- Reset mid-frame: immediate abort, all outputs to reset values, partial word discarded.
- Total latency, line falling edge to data_valid: 2 + HALF + WIDTH*TICKS + TICKS + 1 cycles (±1 for synchroniser phase).

Test Plan:
- CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (TICKS=10, HALF=5), WIDTH=8; send 0xA5 with a 10-cycle bit period -> data=0xA5, data_valid=1, frame_error=0, overrun=0; data_read pulse -> data_valid=0 next cycle, data still 0xA5.
- Line low for 3 cycles then high -> no data_valid, busy returns to 0 within HALF+3 cycles, data unchanged.
- Frame 0x3C with stop bit driven 0 for 20 cycles, then high -> one-cycle frame_error, data_valid stays 0; next valid frame 0x81 after the line goes high -> data=0x81.
- Back-to-back 0x00 then 0xFF, no idle gap, no data_read -> first commit data=0x00; second commit data=0xFF with one overrun pulse, data_valid=1 throughout.
- data_read asserted exactly on the second commit cycle -> no overrun, data=0xFF, data_valid=1.
- resetn low mid-DATA of 0x55 -> all outputs 0 immediately; after release, frame 0x0F -> data=0x0F. Loopback with the transmitter at WIDTH=8 for 16 random bytes -> all match.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver. Reads frames made of one start bit (0), WIDTH
// data bits (LSB first) and one stop bit (1) from an idle-high line. Each
// correctly framed word goes into an output register that uses a valid/read
// handshake. The receiver reports framing errors and overruns as one-cycle
// pulses.
//
// Ports
//   clock        in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   rx_signal    in   serial line, idle high, asynchronous to clock
//   data         out  [WIDTH] last correctly framed word
//   data_valid   out  high while data holds an unread word
//   data_read    in   consumer acknowledge, only observed while data_valid=1
//   frame_error  out  one-cycle pulse when a stop bit is sampled low
//   overrun      out  one-cycle pulse when an unread word is overwritten
//   busy         out  high while the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             rx_signal,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_read,
  output logic             frame_error,
  output logic             overrun,
  output logic             busy
);

  localparam int TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF  = TICKS / 2;
  localparam int CW    = $clog2(TICKS) + 1;
  localparam int BW    = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_line_prev;
  logic [2:0]       r_warm;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [BW-1:0]    r_bit;
  logic [BW-1:0]    w_bit_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             r_busy;
  logic             w_line;
  logic             w_tick;
  logic             w_fall;
  logic             w_commit;
  logic             w_ferr;

  assign w_line = r_sync2;
  assign w_tick = (r_cnt == '0);

  // The synchroniser flops come out of reset preset to 1. This means the
  // first two line values after reset are not real samples. r_warm fills
  // with ones until r_line_prev holds a genuinely sampled value. Because of
  // this, a line that is already low at reset release is not seen as a
  // falling edge.
  assign w_fall = (r_state == S_IDLE) && !w_line && r_line_prev && r_warm[2];

  // ---- Synchroniser and edge history ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
      r_warm      <= '0;
    end else begin
      r_sync1     <= rx_signal;
      r_sync2     <= r_sync1;
      r_line_prev <= w_line;
      r_warm      <= {r_warm[1:0], 1'b1};
    end
  end

  // ---- Next-state and sampling logic ----
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_commit     = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_cnt_next   = CW'(HALF - 1);
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_line) begin
            w_state_next = S_DATA;
            w_bit_next   = '0;
            w_cnt_next   = CW'(TICKS - 1);
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (r_bit == BW'(i)) w_shift_next[i] = w_line;
          end
          w_cnt_next = CW'(TICKS - 1);
          if (r_bit == BW'(WIDTH - 1)) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          // The frame is complete at the mid-stop sample. The receiver goes
          // idle right away so it can accept a back-to-back start edge.
          if (w_line) begin
            w_commit     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (w_line) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---- Control and output registers ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_ferr  <= w_ferr;
      // A read on the commit cycle consumes the old word. In that case the
      // new word replaces it without an overrun.
      r_ovr   <= w_commit && r_valid && !data_read;
      if (w_commit) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && data_read) begin
        r_valid <= 1'b0;
      end
    end
  end

  // The shift register is overwritten bit by bit in every frame. A partial
  // word never reaches the output, so this register needs no reset.
  always_ff @(posedge clock) begin
    r_shift <= w_shift_next;
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign frame_error = r_ferr;
  assign overrun     = r_ovr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. It runs at 1 MHz / 100 kbaud, so one bit lasts
// 10 clocks. The bench plays the transmitter. A negedge monitor counts the
// cycles in which the pulse outputs are high.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int W  = 8;
  localparam int BP = CF / BR;

  logic         clock;
  logic         resetn;
  logic         rx_signal;
  logic [W-1:0] data;
  logic         data_valid;
  logic         data_read;
  logic         frame_error;
  logic         overrun;
  logic         busy;

  int n_vec;
  int n_err;
  int fe_cyc;
  int ov_cyc;
  int both_cyc;
  int busy_cyc;
  int vlow_cyc;
  bit watch_v;

  uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .WIDTH(W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rx_signal  (rx_signal),
    .data       (data),
    .data_valid (data_valid),
    .data_read  (data_read),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    fe_cyc = 0; ov_cyc = 0; both_cyc = 0; busy_cyc = 0; vlow_cyc = 0;
  end

  always @(negedge clock) begin
    if (frame_error) fe_cyc++;
    if (overrun) ov_cyc++;
    if (frame_error && overrun) both_cyc++;
    if (busy) busy_cyc++;
    if (watch_v && !data_valid) vlow_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The caller is at posedge+1. The task returns at posedge+1.
  task automatic drive_bit(input logic b);
    rx_signal = b;
    repeat (BP) @(posedge clock);
    #1;
  endtask

  // rd_idx >= 0 raises data_read for one cycle during the stop bit. Index 6
  // is the cycle whose closing edge is the stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_idx);
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
    rx_signal = stop;
    for (int i = 0; i < BP; i++) begin
      @(posedge clock);
      #1;
      data_read = (i == rd_idx);
    end
    data_read = 1'b0;
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    @(posedge clock);
    #1;
    data_read = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_signal = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int fe0, ov0, bz0, vl0, bo0;
    logic [7:0] b;
    n_vec = 0; n_err = 0; watch_v = 1'b0;
    rx_signal = 1'b1; data_read = 1'b0; resetn = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    idle(10);

    // Plain frame 0xA5, then read
    fe0 = fe_cyc; ov0 = ov_cyc;
    send_frame(8'hA5, 1'b1, -1);
    chk("a5_data", data, 8'hA5);
    chk("a5_valid", data_valid, 1);
    chk("a5_fe", fe_cyc - fe0, 0);
    chk("a5_ov", ov_cyc - ov0, 0);
    chk("a5_busy", busy, 0);
    read_pulse();
    chk("a5_rd_valid", data_valid, 0);
    chk("a5_rd_data", data, 8'hA5);

    // Start glitch: line low for 3 cycles only
    bz0 = busy_cyc;
    rx_signal = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    idle(12);
    chk("gl_busy_seen", (busy_cyc - bz0) > 0 && (busy_cyc - bz0) <= 5 + 3, 1);
    chk("gl_busy", busy, 0);
    chk("gl_valid", data_valid, 0);
    chk("gl_data", data, 8'hA5);

    // Bad stop bit held low for 20 cycles, then a good frame
    fe0 = fe_cyc; bo0 = both_cyc;
    send_frame(8'h3C, 1'b0, -1);
    rx_signal = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    idle(10);
    chk("fe_pulse", fe_cyc - fe0, 1);
    chk("fe_valid", data_valid, 0);
    chk("fe_data", data, 8'hA5);
    chk("fe_busy", busy, 0);
    send_frame(8'h81, 1'b1, -1);
    chk("fe_next_data", data, 8'h81);
    chk("fe_next_valid", data_valid, 1);
    read_pulse();

    // Back-to-back 0x00, 0xFF without reads
    ov0 = ov_cyc;
    send_frame(8'h00, 1'b1, -1);
    chk("b2b_first_data", data, 8'h00);
    chk("b2b_first_valid", data_valid, 1);
    chk("b2b_first_ov", ov_cyc - ov0, 0);
    vl0 = vlow_cyc;
    watch_v = 1'b1;
    send_frame(8'hFF, 1'b1, -1);
    watch_v = 1'b0;
    chk("b2b_second_data", data, 8'hFF);
    chk("b2b_ov_pulse", ov_cyc - ov0, 1);
    chk("b2b_valid_held", vlow_cyc - vl0, 0);
    chk("b2b_no_both", both_cyc - bo0, 0);

    // Read lands exactly on the second commit cycle
    read_pulse();
    ov0 = ov_cyc;
    send_frame(8'h00, 1'b1, -1);
    chk("rdc_first_valid", data_valid, 1);
    vl0 = vlow_cyc;
    watch_v = 1'b1;
    send_frame(8'hFF, 1'b1, 6);
    watch_v = 1'b0;
    chk("rdc_data", data, 8'hFF);
    chk("rdc_valid", data_valid, 1);
    chk("rdc_no_ov", ov_cyc - ov0, 0);
    chk("rdc_valid_held", vlow_cyc - vl0, 0);

    // Reset in the middle of DATA for 0x55
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    #2;
    chk("mid_rst_data", data, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fe", frame_error, 0);
    chk("mid_rst_ov", overrun, 0);
    rx_signal = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    idle(5);
    send_frame(8'h0F, 1'b1, -1);
    chk("post_rst_data", data, 8'h0F);
    chk("post_rst_valid", data_valid, 1);
    read_pulse();

    // Random bytes from the bench transmitter
    fe0 = fe_cyc; ov0 = ov_cyc;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, -1);
      chk("loop_data", data, b);
      chk("loop_valid", data_valid, 1);
      read_pulse();
      idle(k % 3);
    end
    chk("loop_fe", fe_cyc - fe0, 0);
    chk("loop_ov", ov_cyc - ov0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
